// File: rtl/rv32i_fetch_queue.sv
// RV32I instruction fetch queue: issues word-aligned fetches to a fixed one-cycle-latency
// instruction memory and buffers {pc, inst, fault} entries for the decode/execute stage.
module rv32i_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_wait,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_badmem_e,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_badmem
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HALT  = 1'b1;

    logic [0:0]      state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [DEPTH-1:0] bad_mem;

    logic            accept;
    logic            push;
    logic            pop;
    logic            fault_arriving;
    logic [PW+1:0]   occupancy;
    logic            redirect_lo_unused;

    assign redirect_lo_unused = ^redirect_pc[1:0];

    assign occupancy      = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
    // A faulting response halts fetch this very cycle, so the next sequential address is never requested.
    assign fault_arriving = inflight && imem_badmem_e;
    assign imem_req_valid = (state == FETCH) && !redirect_valid && !reset
                            && (occupancy < {1'b0, FULL}) && !fault_arriving;
    assign imem_addr      = fetch_pc;
    assign accept         = imem_req_valid && !imem_wait;

    assign push      = inflight && !redirect_valid && !reset;
    assign out_valid = (count != '0) && !redirect_valid && !reset;
    assign pop       = out_valid && out_ready;

    assign out_pc     = pc_mem[head];
    assign out_inst   = inst_mem[head];
    assign out_badmem = bad_mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            state    <= FETCH;
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                fetch_pc    <= fetch_pc + XLEN'(4);
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                tail <= tail + PW'(1);
                if (imem_badmem_e) begin
                    state <= HALT;
                end
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= inflight_pc;
            inst_mem[tail] <= imem_rdata;
            bad_mem[tail]  <= imem_badmem_e;
        end
    end

    // Request throttling must keep this unreachable.
    assert property (@(posedge clk) disable iff (reset) !(push && count == FULL));

endmodule
